// File: rtl/encrypt_v2_pkg.sv
// Shared definitions for the iterative PRESENT-80 engine: widths, round
// count, controller state encodings and the 4-bit S-box.
package encrypt_v2_pkg;

  localparam int unsigned N_K = 80;  // cipher key width
  localparam int unsigned N_B = 64;  // block width
  localparam int unsigned N_R = 31;  // full rounds before final whitening

  localparam logic [4:0] R_LAST = 5'(N_R);

  typedef logic [N_K-1:0] key_t;
  typedef logic [N_B-1:0] block_t;

  // Controller encodings, kept identical to the legacy header values.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/encrypt_v2_if.sv
// Host-side bus of the encryption engine: 4-phase req/ack handshake plus
// key/plaintext inputs and ciphertext output.
//   master: drives req, k, m; observes ack, c (host)
//   slave : observes req, k, m; drives ack, c (engine)
interface encrypt_v2_if;
  import encrypt_v2_pkg::*;

  logic   req;
  logic   ack;
  key_t   k;
  block_t m;
  block_t c;

  modport master (output req, output k, output m, input ack, input c);
  modport slave  (input req, input k, input m, output ack, output c);

endinterface

// File: rtl/encrypt_v2_present_round.sv
// One PRESENT-80 round, purely combinational.
//   state_i/key_i : current cipher state and round key register
//   r_i           : round index (1..31) mixed into the key schedule
//   state_o       : pLayer(sBox(state_i ^ key_i[79:16]))
//   key_o         : next key register value
module present_round
  import encrypt_v2_pkg::*;
(
  input  block_t     state_i,
  input  key_t       key_i,
  input  logic [4:0] r_i,
  output block_t     state_o,
  output key_t       key_o
);

  block_t x;
  block_t s;
  key_t   rot;

  assign x = state_i ^ key_i[N_K-1 -: N_B];

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    assign s[4*g +: 4] = sbox(x[4*g +: 4]);
  end

  // pLayer: bit i moves to 16*i mod 63; bit 63 stays put.
  for (genvar g = 0; g < 63; g++) begin : g_perm
    assign state_o[(16*g) % 63] = s[g];
  end
  assign state_o[63] = s[63];

  // Rotate left by 61, substitute the top nibble, inject the round index.
  assign rot   = {key_i[18:0], key_i[79:19]};
  assign key_o = {sbox(rot[79:76]), rot[75:20], rot[19:15] ^ r_i, rot[14:0]};

endmodule

// File: rtl/encrypt_v2.sv
// Iterative PRESENT-80 encryption engine: one round per clock under a small
// controller, 4-phase req/ack handshake to the host.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   host : slave side of encrypt_v2_if (req/k/m in, ack/c out)
// Latency: ack rises on the 32nd rising edge after the capture edge.
module encrypt_v2
  import encrypt_v2_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  encrypt_v2_if.slave  host
);

  logic [1:0] fsm_q, fsm_d;
  logic [4:0] r_q, r_d;
  block_t     state_q, state_d;
  key_t       key_q, key_d;
  block_t     c_q, c_d;
  logic       ack_q, ack_d;

  block_t     rnd_state;
  key_t       rnd_key;

  present_round u_round (
    .state_i (state_q),
    .key_i   (key_q),
    .r_i     (r_q),
    .state_o (rnd_state),
    .key_o   (rnd_key)
  );

  always_comb begin
    fsm_d   = fsm_q;
    r_d     = r_q;
    state_d = state_q;
    key_d   = key_q;
    c_d     = c_q;
    ack_d   = ack_q;
    case (fsm_q)
      S_IDLE: begin
        if (host.req) begin
          state_d = host.m;
          key_d   = host.k;
          r_d     = 5'd1;
          fsm_d   = S_ROUND;
        end
      end
      S_ROUND: begin
        state_d = rnd_state;
        key_d   = rnd_key;
        // Counter saturates at the last round instead of wrapping.
        if (r_q == R_LAST) fsm_d = S_FINAL;
        else               r_d   = r_q + 5'd1;
      end
      S_FINAL: begin
        c_d   = state_q ^ key_q[N_K-1 -: N_B];
        ack_d = 1'b1;
        fsm_d = S_DONE;
      end
      S_DONE: begin
        if (!host.req) begin
          ack_d = 1'b0;
          fsm_d = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= S_IDLE;
      r_q     <= '0;
      state_q <= '0;
      key_q   <= '0;
      c_q     <= '0;
      ack_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      r_q     <= r_d;
      state_q <= state_d;
      key_q   <= key_d;
      c_q     <= c_d;
      ack_q   <= ack_d;
    end
  end

  assign host.ack = ack_q;
  assign host.c   = c_q;

endmodule

// File: tb/tb_encrypt_v2.sv
module tb_encrypt_v2;
  import encrypt_v2_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  encrypt_v2_if ifc ();

  encrypt_v2 dut (
    .clk  (clk),
    .rst  (rst),
    .host (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] SB_TABLE = 64'h2174_8FE3_DA09_B65C;

  function automatic logic [3:0] ref_sbox(input logic [3:0] n);
    logic [63:0] tbl;
    tbl = SB_TABLE;
    return tbl[4*n +: 4];
  endfunction

  // Reference PRESENT-80 straight from the algorithm description.
  function automatic logic [63:0] present_ref(input logic [79:0] key, input logic [63:0] blk);
    logic [63:0] t;
    logic [63:0] p;
    for (int rnd = 1; rnd <= 31; rnd++) begin
      t = blk ^ key[79:16];
      for (int n = 0; n < 16; n++) t[4*n +: 4] = ref_sbox(t[4*n +: 4]);
      for (int b = 0; b < 64; b++) p[(b == 63) ? 63 : (16*b) % 63] = t[b];
      blk = p;
      key = {key[18:0], key[79:19]};
      key[79:76] = ref_sbox(key[79:76]);
      key[19:15] = key[19:15] ^ 5'(rnd);
    end
    return blk ^ key[79:16];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Capture edge E0, then count edges until ack (bounded).
  task automatic start_and_wait(input logic [79:0] kk, input logic [63:0] mm,
                                output int edges);
    ifc.k   = kk;
    ifc.m   = mm;
    ifc.req = 1'b1;
    tick();
    edges = 0;
    while (ifc.ack !== 1'b1 && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  task automatic release_req();
    ifc.req = 1'b0;
    tick();
    checks++;
    if (ifc.ack !== 1'b0) begin
      failures++;
      $display("FAIL ack_fall: ack=%b expected 0", ifc.ack);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.req = 1'b1;
    ifc.k = '1;
    ifc.m = '1;
    #1;
    checks++;
    if (ifc.ack !== 1'b0 || ifc.c !== 64'h0) begin
      failures++;
      $display("FAIL reset_state: ack=%b c=%h expected 0/0", ifc.ack, ifc.c);
    end
    repeat (3) tick();
    checks++;
    if (ifc.ack !== 1'b0 || ifc.c !== 64'h0) begin
      failures++;
      $display("FAIL reset_hold: ack=%b c=%h expected 0/0", ifc.ack, ifc.c);
    end
    ifc.req = 1'b0;
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_kat();
    logic [79:0] kv [4];
    logic [63:0] mv [4];
    logic [63:0] cv [4];
    int e;
    kv = '{80'h0, {80{1'b1}}, 80'h0, {80{1'b1}}};
    mv = '{64'h0, 64'h0, {64{1'b1}}, {64{1'b1}}};
    cv = '{64'h5579c1387b228445, 64'he72c46c0f5945049,
           64'ha112ffc72f68417b, 64'h3333dcd3213210d2};
    for (int i = 0; i < 4; i++) begin
      start_and_wait(kv[i], mv[i], e);
      checks++;
      if (e != 32 || ifc.c !== cv[i]) begin
        failures++;
        $display("FAIL kat%0d: edges=%0d c=%h expected 32 %h", i, e, ifc.c, cv[i]);
      end
      release_req();
    end
  endtask

  task automatic test_latency_hold();
    logic [63:0] exp_c;
    exp_c = 64'h5579c1387b228445;
    ifc.k = '0;
    ifc.m = '0;
    ifc.req = 1'b1;
    tick();
    for (int i = 1; i <= 31; i++) begin
      tick();
      checks++;
      if (ifc.ack !== 1'b0) begin
        failures++;
        $display("FAIL latency_early E%0d: ack=%b expected 0", i, ifc.ack);
      end
    end
    tick();
    checks++;
    if (ifc.ack !== 1'b1 || ifc.c !== exp_c) begin
      failures++;
      $display("FAIL latency_E32: ack=%b c=%h expected 1 %h", ifc.ack, ifc.c, exp_c);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (ifc.ack !== 1'b1 || ifc.c !== exp_c) begin
        failures++;
        $display("FAIL hold%0d: ack=%b c=%h expected 1 %h", i, ifc.ack, ifc.c, exp_c);
      end
    end
    release_req();
    checks++;
    if (ifc.c !== exp_c) begin
      failures++;
      $display("FAIL c_retain: c=%h expected %h", ifc.c, exp_c);
    end
  endtask

  task automatic test_input_corruption();
    logic [63:0] exp_c;
    int edges;
    exp_c = 64'h5579c1387b228445;
    ifc.k = '0;
    ifc.m = '0;
    ifc.req = 1'b1;
    tick();
    edges = 0;
    while (ifc.ack !== 1'b1 && edges < 40) begin
      tick();
      edges++;
      if (edges == 5) begin
        ifc.k = {16'($urandom), $urandom, $urandom};
        ifc.m = {$urandom, $urandom};
      end
      if (edges == 10) ifc.req = 1'b0;
    end
    checks++;
    if (edges != 32 || ifc.c !== exp_c) begin
      failures++;
      $display("FAIL corrupt_result: edges=%0d c=%h expected 32 %h", edges, ifc.c, exp_c);
    end
    tick();
    checks++;
    if (ifc.ack !== 1'b0) begin
      failures++;
      $display("FAIL corrupt_pulse: ack=%b expected 0", ifc.ack);
    end
    repeat (3) tick();
    checks++;
    if (ifc.ack !== 1'b0 || ifc.c !== exp_c) begin
      failures++;
      $display("FAIL corrupt_idle: ack=%b c=%h expected 0 %h", ifc.ack, ifc.c, exp_c);
    end
  endtask

  task automatic test_async_reset();
    logic [79:0] kk;
    logic [63:0] mm;
    int e;
    ifc.k = {80{1'b1}};
    ifc.m = '0;
    ifc.req = 1'b1;
    tick();
    repeat (15) tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ifc.ack !== 1'b0 || ifc.c !== 64'h0) begin
      failures++;
      $display("FAIL async_reset: ack=%b c=%h expected 0/0", ifc.ack, ifc.c);
    end
    kk = {16'($urandom), $urandom, $urandom};
    mm = {$urandom, $urandom};
    ifc.k = kk;
    ifc.m = mm;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    e = 0;
    while (ifc.ack !== 1'b1 && e < 40) begin
      tick();
      e++;
    end
    checks++;
    if (e != 32 || ifc.c !== present_ref(kk, mm)) begin
      failures++;
      $display("FAIL after_reset: edges=%0d c=%h expected 32 %h", e, ifc.c, present_ref(kk, mm));
    end
    release_req();
  endtask

  task automatic test_back_to_back();
    logic [79:0] kk;
    logic [63:0] mm;
    logic [63:0] exp_c;
    int e;
    for (int i = 0; i < 24; i++) begin
      kk = {16'($urandom), $urandom, $urandom};
      mm = {$urandom, $urandom};
      exp_c = present_ref(kk, mm);
      start_and_wait(kk, mm, e);
      checks++;
      if (e != 32 || ifc.c !== exp_c) begin
        failures++;
        $display("FAIL sweep%0d: edges=%0d c=%h expected 32 %h", i, e, ifc.c, exp_c);
      end
      ifc.req = 1'b0;
      tick();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    ifc.req = 1'b0;
    ifc.k = '0;
    ifc.m = '0;
    test_reset();
    test_kat();
    test_latency_hold();
    test_input_corruption();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
